// File: rtl/wb_initiator_timeout_slice.sv
// Wishbone initiator-side register slice. Registers the request toward the
// interconnect and the response back toward the initiator, and terminates a
// transfer with err+timeout if no target answers within TIMEOUT cycles of the
// request being presented.
module wb_initiator_timeout_slice #(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WB_ADDR_WIDTH-1:0]     adr,
    input  logic [WB_DATA_WIDTH-1:0]     dat_w,
    output logic [WB_DATA_WIDTH-1:0]     dat_r,
    input  logic                         cyc,
    input  logic                         stb,
    input  logic [WB_DATA_WIDTH/8-1:0]   sel,
    input  logic                         we,
    output logic                         ack,
    output logic                         err,
    output logic [WB_ADDR_WIDTH-1:0]     tadr,
    output logic [WB_DATA_WIDTH-1:0]     tdat_w,
    input  logic [WB_DATA_WIDTH-1:0]     tdat_r,
    output logic                         tcyc,
    output logic                         tstb,
    output logic [WB_DATA_WIDTH/8-1:0]   tsel,
    output logic                         twe,
    input  logic                         tack,
    input  logic                         terr,
    output logic                         timeout
);

    localparam int unsigned SEL_WIDTH  = WB_DATA_WIDTH / 8;
    localparam int unsigned CNT_CLOG   = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_WIDTH  = (CNT_CLOG < 1) ? 1 : CNT_CLOG;
    localparam int unsigned CNT_LAST   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [WB_ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [WB_DATA_WIDTH-1:0]   dat_w_q, dat_w_d;
    logic [SEL_WIDTH-1:0]       sel_q, sel_d;
    logic                       we_q, we_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic [WB_DATA_WIDTH-1:0]   dat_r_q, dat_r_d;
    logic                       ack_q, ack_d;
    logic                       err_q, err_d;
    logic                       timeout_q, timeout_d;
    logic                       tcyc_q, tcyc_d;

    // Next-state, capture, response and counter logic.
    // The first BUSY cycle launches the request (tcyc/tstb rise on the
    // following edge); responses and the timeout counter only act once the
    // request is actually visible to the interconnect.
    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_w_d   = dat_w_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        dat_r_d   = dat_r_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        timeout_d = 1'b0;
        tcyc_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cyc && stb) begin
                    adr_d   = adr;
                    dat_w_d = dat_w;
                    sel_d   = sel;
                    we_d    = we;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                if (!cyc) begin
                    state_d = S_IDLE;
                end else if (tcyc_q) begin
                    if (cnt_q != {CNT_WIDTH{1'b1}}) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                    if (terr) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else if (tack) begin
                        dat_r_d = tdat_r;
                        ack_d   = 1'b1;
                        state_d = S_RESP;
                    end else if ((TIMEOUT != 0) && (cnt_q == CNT_WIDTH'(CNT_LAST))) begin
                        err_d     = 1'b1;
                        timeout_d = 1'b1;
                        dat_r_d   = '0;
                        state_d   = S_RESP;
                    end else begin
                        tcyc_d = 1'b1;
                    end
                end else begin
                    tcyc_d = 1'b1;
                end
            end

            S_RESP: begin
                if (cyc && stb) begin
                    adr_d   = adr;
                    dat_w_d = dat_w;
                    sel_d   = sel;
                    we_d    = we;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            dat_w_q   <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            dat_r_q   <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
            tcyc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_w_q   <= dat_w_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            dat_r_q   <= dat_r_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
            tcyc_q    <= tcyc_d;
        end
    end

    assign dat_r   = dat_r_q;
    assign ack     = ack_q;
    assign err     = err_q;
    assign timeout = timeout_q;
    assign tadr    = adr_q;
    assign tdat_w  = dat_w_q;
    assign tsel    = sel_q;
    assign twe     = we_q;
    assign tcyc    = tcyc_q;
    assign tstb    = tcyc_q;

endmodule

// File: tb/tb_wb_initiator_timeout_slice.sv
// Self-checking bench for wb_initiator_timeout_slice (TIMEOUT=8).
module tb_wb_initiator_timeout_slice;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 8;

    typedef struct {
        logic        is_err;
        logic        is_to;
        logic        chk_data;
        logic [31:0] data;
        int          lat;
    } exp_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [DW-1:0] dat_r;
    logic          cyc;
    logic          stb;
    logic [SW-1:0] sel;
    logic          we;
    logic          ack;
    logic          err;
    logic [AW-1:0] tadr;
    logic [DW-1:0] tdat_w;
    logic [DW-1:0] tdat_r;
    logic          tcyc;
    logic          tstb;
    logic [SW-1:0] tsel;
    logic          twe;
    logic          tack;
    logic          terr;
    logic          timeout;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int tgt_wait;
    int tgt_mode;      // 0 ack, 1 err, 2 ack+err, 3 silent
    logic [31:0] tgt_data;
    int bsy_cnt;
    exp_t sb[$];

    wb_initiator_timeout_slice #(
        .WB_ADDR_WIDTH(AW),
        .WB_DATA_WIDTH(DW),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .adr(adr), .dat_w(dat_w), .dat_r(dat_r),
        .cyc(cyc), .stb(stb), .sel(sel), .we(we),
        .ack(ack), .err(err),
        .tadr(tadr), .tdat_w(tdat_w), .tdat_r(tdat_r),
        .tcyc(tcyc), .tstb(tstb), .tsel(tsel), .twe(twe),
        .tack(tack), .terr(terr), .timeout(timeout)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc_n++;
    endtask

    // Target model: answers on the (tgt_wait+1)-th cycle of a visible strobe.
    task automatic target_model();
        tack   = 1'b0;
        terr   = 1'b0;
        tdat_r = 32'h5A5A_5A5A;
        if (tstb) begin
            bsy_cnt++;
            if (bsy_cnt == tgt_wait + 1) begin
                tack   = (tgt_mode == 0) || (tgt_mode == 2);
                terr   = (tgt_mode == 1) || (tgt_mode == 2);
                tdat_r = tgt_data;
            end
        end else begin
            bsy_cnt = 0;
        end
    endtask

    task automatic test_reset();
        logic [105:0] obs;
        reset = 1'b0; cyc = 1'b1; stb = 1'b1; adr = 32'h2800_0100; we = 1'b0;
        dat_w = 32'h0; sel = 4'hF; tack = 1'b0; terr = 1'b0; tdat_r = 32'h0;
        tgt_mode = 3; tgt_wait = 0; tgt_data = 32'h0; bsy_cnt = 0;
        repeat (2) begin
            tick();
            obs = {dat_r, ack, err, timeout, tadr, tdat_w, tcyc, tstb, tsel, twe};
            checks++;
            if (obs !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs); end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (tstb !== 1'b0) begin errors++; $display("FAIL reset_capture_edge tstb: got %b expected 0", tstb); end
        tick();
        checks++;
        if (tstb !== 1'b1 || tadr !== 32'h2800_0100) begin
            errors++; $display("FAIL reset_release_launch: tstb=%b tadr=%h expected 1 28000100", tstb, tadr);
        end
        reset = 1'b0;
        tick();
        obs = {dat_r, ack, err, timeout, tadr, tdat_w, tcyc, tstb, tsel, twe};
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_mid_transfer: got %h expected 0", obs); end
        reset = 1'b1; cyc = 1'b0; stb = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if ({tcyc, ack, err} !== 3'b000) begin
                errors++; $display("FAIL reset_no_response: tcyc/ack/err=%b expected 000", {tcyc, ack, err});
            end
        end
    endtask

    task automatic test_read();
        exp_t e;
        int t0;
        bit done = 1'b0;
        tgt_wait = 2; tgt_mode = 0; tgt_data = 32'hDEAD_BEEF; bsy_cnt = 0;
        adr = 32'h2800_0010; we = 1'b0; dat_w = 32'h0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        t0 = cyc_n + 1;
        sb.push_back('{is_err: 1'b0, is_to: 1'b0, chk_data: 1'b1, data: 32'hDEAD_BEEF, lat: 4});
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            target_model();
            if (tstb) begin
                checks++;
                if (tadr !== 32'h2800_0010 || twe !== 1'b0) begin
                    errors++; $display("FAIL read_tadr: tadr=%h twe=%b expected 28000010 0", tadr, twe);
                end
            end
            if (ack || err) begin
                e = sb.pop_front();
                done = 1'b1; cyc = 1'b0; stb = 1'b0;
                checks++;
                if ({ack, err, timeout} !== {~e.is_err, e.is_err, e.is_to}) begin
                    errors++; $display("FAIL read_flags: ack/err/to=%b expected %b", {ack, err, timeout}, {~e.is_err, e.is_err, e.is_to});
                end
                checks++;
                if (dat_r !== e.data) begin errors++; $display("FAIL read_data: got %h expected %h", dat_r, e.data); end
                checks++;
                if (cyc_n - t0 != e.lat) begin errors++; $display("FAIL read_latency: got %0d expected %0d", cyc_n - t0, e.lat); end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL read_no_response: got none expected ack"); end
        tick();
        target_model();
        checks++;
        if (ack !== 1'b0 || dat_r !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_pulse_hold: ack=%b dat_r=%h expected 0 deadbeef", ack, dat_r);
        end
    endtask

    task automatic test_write();
        exp_t e;
        int t0;
        bit done = 1'b0;
        tgt_wait = 0; tgt_mode = 0; tgt_data = 32'hA5A5_0001; bsy_cnt = 0;
        adr = 32'h1000_0008; we = 1'b1; dat_w = 32'h1234_5678; sel = 4'b0011; cyc = 1'b1; stb = 1'b1;
        t0 = cyc_n + 1;
        sb.push_back('{is_err: 1'b0, is_to: 1'b0, chk_data: 1'b1, data: 32'hA5A5_0001, lat: 2});
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            target_model();
            if (tstb) begin
                checks++;
                if (tdat_w !== 32'h1234_5678 || tsel !== 4'b0011 || twe !== 1'b1 || tadr !== 32'h1000_0008) begin
                    errors++; $display("FAIL write_fields: tdat_w=%h tsel=%b twe=%b tadr=%h expected 12345678 0011 1 10000008", tdat_w, tsel, twe, tadr);
                end
            end
            if (ack || err) begin
                e = sb.pop_front();
                done = 1'b1; cyc = 1'b0; stb = 1'b0;
                checks++;
                if ({ack, err, timeout} !== {~e.is_err, e.is_err, e.is_to}) begin
                    errors++; $display("FAIL write_flags: ack/err/to=%b expected %b", {ack, err, timeout}, {~e.is_err, e.is_err, e.is_to});
                end
                checks++;
                if (dat_r !== e.data) begin errors++; $display("FAIL write_data: got %h expected %h", dat_r, e.data); end
                checks++;
                if (cyc_n - t0 != e.lat) begin errors++; $display("FAIL write_latency: got %0d expected %0d", cyc_n - t0, e.lat); end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL write_no_response: got none expected ack"); end
    endtask

    task automatic test_timeout();
        exp_t e;
        int t0;
        int rise = -1;
        bit done = 1'b0;
        tgt_wait = 0; tgt_mode = 3; tgt_data = 32'h0; bsy_cnt = 0;
        adr = 32'h9000_0000; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        t0 = cyc_n + 1;
        sb.push_back('{is_err: 1'b1, is_to: 1'b1, chk_data: 1'b1, data: 32'h0, lat: TO + 1});
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            target_model();
            if (tstb && rise < 0) rise = cyc_n;
            if (ack || err) begin
                e = sb.pop_front();
                done = 1'b1; cyc = 1'b0; stb = 1'b0;
                checks++;
                if ({ack, err, timeout} !== {~e.is_err, e.is_err, e.is_to}) begin
                    errors++; $display("FAIL timeout_flags: ack/err/to=%b expected %b", {ack, err, timeout}, {~e.is_err, e.is_err, e.is_to});
                end
                checks++;
                if (dat_r !== e.data) begin errors++; $display("FAIL timeout_data: got %h expected %h", dat_r, e.data); end
                checks++;
                if (cyc_n - t0 != e.lat) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", cyc_n - t0, e.lat); end
                checks++;
                if (cyc_n - rise != TO) begin errors++; $display("FAIL timeout_from_tstb: got %0d expected %0d", cyc_n - rise, TO); end
                checks++;
                if (tcyc !== 1'b0) begin errors++; $display("FAIL timeout_tcyc_drop: got %b expected 0", tcyc); end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL timeout_no_response: got none expected err"); end
        tick();
        checks++;
        if ({ack, err, timeout} !== 3'b000) begin
            errors++; $display("FAIL timeout_pulse: ack/err/to=%b expected 000", {ack, err, timeout});
        end
    endtask

    task automatic test_err_priority();
        exp_t e;
        int t0;
        bit done = 1'b0;
        tgt_wait = 1; tgt_mode = 2; tgt_data = 32'h7777_0000; bsy_cnt = 0;
        adr = 32'h2800_0040; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        t0 = cyc_n + 1;
        sb.push_back('{is_err: 1'b1, is_to: 1'b0, chk_data: 1'b0, data: 32'h0, lat: 3});
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            target_model();
            if (ack || err) begin
                e = sb.pop_front();
                done = 1'b1; cyc = 1'b0; stb = 1'b0;
                checks++;
                if ({ack, err, timeout} !== {~e.is_err, e.is_err, e.is_to}) begin
                    errors++; $display("FAIL errprio_flags: ack/err/to=%b expected %b", {ack, err, timeout}, {~e.is_err, e.is_err, e.is_to});
                end
                checks++;
                if (cyc_n - t0 != e.lat) begin errors++; $display("FAIL errprio_latency: got %0d expected %0d", cyc_n - t0, e.lat); end
            end
        end
        checks++;
        if (!done) begin errors++; $display("FAIL errprio_no_response: got none expected err"); end
    endtask

    task automatic test_abort();
        bit dropped = 1'b0;
        tgt_wait = 3; tgt_mode = 0; tgt_data = 32'h3333_3333; bsy_cnt = 0;
        adr = 32'h2800_0020; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        for (int i = 0; i < 10 && !dropped; i++) begin
            tick();
            target_model();
            if (bsy_cnt == 2) begin
                cyc = 1'b0; stb = 1'b0; dropped = 1'b1;
            end
        end
        checks++;
        if (!dropped) begin errors++; $display("FAIL abort_no_busy: got no strobe expected 2 busy cycles"); end
        tick();
        checks++;
        if (tcyc !== 1'b0) begin errors++; $display("FAIL abort_tcyc: got %b expected 0", tcyc); end
        repeat (4) begin
            tack = 1'b1; tdat_r = 32'h3333_3333;
            tick();
            checks++;
            if ({ack, err, tcyc} !== 3'b000) begin
                errors++; $display("FAIL abort_late_tack: ack/err/tcyc=%b expected 000", {ack, err, tcyc});
            end
        end
        tack = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int t0;
        int first_ack = 0;
        int n = 0;
        logic [31:0] cur;
        tgt_wait = 0; tgt_mode = 0; tgt_data = 32'h1111_0000; bsy_cnt = 0;
        cur = 32'h2800_0000;
        adr = cur; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        t0 = cyc_n + 1;
        sb.push_back('{is_err: 1'b0, is_to: 1'b0, chk_data: 1'b1, data: 32'h1111_0000, lat: 2});
        sb.push_back('{is_err: 1'b0, is_to: 1'b0, chk_data: 1'b1, data: 32'h2222_0004, lat: 3});
        for (int i = 0; i < 30 && n < 2; i++) begin
            tick();
            target_model();
            if (tstb) begin
                checks++;
                if (tadr !== cur) begin errors++; $display("FAIL b2b_tadr: got %h expected %h", tadr, cur); end
            end
            if (ack || err) begin
                e = sb.pop_front();
                checks++;
                if ({ack, err, timeout} !== {~e.is_err, e.is_err, e.is_to}) begin
                    errors++; $display("FAIL b2b_flags: ack/err/to=%b expected %b", {ack, err, timeout}, {~e.is_err, e.is_err, e.is_to});
                end
                checks++;
                if (dat_r !== e.data) begin errors++; $display("FAIL b2b_data: got %h expected %h", dat_r, e.data); end
                if (n == 0) begin
                    checks++;
                    if (cyc_n - t0 != e.lat) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", cyc_n - t0, e.lat); end
                    first_ack = cyc_n;
                    cur = 32'h2800_0004;
                    adr = cur;
                    tgt_data = 32'h2222_0004;
                end else begin
                    checks++;
                    if (cyc_n - first_ack != e.lat) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", cyc_n - first_ack, e.lat); end
                    cyc = 1'b0; stb = 1'b0;
                end
                n++;
            end
        end
        checks++;
        if (n != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", n); end
    endtask

    initial begin
        test_reset();
        test_read();
        repeat (2) tick();
        test_write();
        repeat (2) tick();
        test_timeout();
        repeat (2) tick();
        test_err_priority();
        repeat (2) tick();
        test_abort();
        repeat (2) tick();
        test_back_to_back();
        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
